uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive stage of the full UART, directly downstream of the two-stage `dflop` synchronizer that retimes the asynchronous RX pin. It consumes the synchronized line and oversamples it at 16× the baud rate. It deframes start/data/stop bits, LSB first, and presents each received byte in a holding register with a ready/read handshake and error flags to the host-side logic.

## Interface
- `BAUD_DIV`, 326: clk cycles per oversample tick, equal to f_clk / (16 × baud); 50 MHz / (16 × 9600) ≈ 326.
- `DATA_BITS`, 8: data bits per frame, legal range 5–8.
- `PARITY_ODD`, 0: with parity compiled in, 0 selects even parity and 1 selects odd.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rx_s`, input, 1: synchronized serial line from the `dflop` chain; idle high.
- `rd`, input, 1: one-cycle strobe; host has consumed `rx_data`.
- `rx_data`, output, DATA_BITS: last accepted byte; unused upper bits are 0.
- `rx_rdy`, output, 1: holding register contains an unread byte.
- `frame_err`, output, 1: stop bit of the accepted byte sampled 0.
- `parity_err`, output, 1: parity mismatch on the accepted byte.
- `overrun`, output, 1: a frame completed while `rx_rdy` was high and was discarded.

## Operation
- Reset values: every output is 0, the state is IDLE, and all counters are 0.
- Tick generator: a free-running counter from 0 to BAUD_DIV−1 asserts `tick` for one clk when the count equals BAUD_DIV−1.
- Per-state 4-bit oversample counter `os_cnt`:
  - It advances only on `tick`.
  - It clears on every state entry.
- FSM states and transitions:
  - **IDLE**: `rx_s`=0 on a tick moves to START with `os_cnt`=0.
  - **START**: at `os_cnt`=7, mid-bit:
    - If `rx_s`=1, this is a false start; return to IDLE.
    - Otherwise move to DATA with `os_cnt`=0 and `bit_cnt`=0.
  - **DATA**: at `os_cnt`=15, one bit later than the previous sample and therefore mid-bit:
    - Shift `rx_s` into the MSB of the shift register, so the LSB arrives first.
    - After DATA_BITS samples, go to PARITY if it is enabled, else to STOP.
  - **PARITY**: sample at `os_cnt`=15 and compute the mismatch.
  - **STOP**: sample at `os_cnt`=15.
    - Perform the accept/overrun action below.
    - Return to IDLE the same cycle, without waiting for the end of the stop bit.
- Accept (STOP sample with `rx_rdy`=0, or with `rd`=1 in the same cycle):
  - Load `rx_data`, `frame_err` (= !`rx_s`) and `parity_err`.
  - Set `rx_rdy` and clear `overrun`.
- Discard (STOP sample with `rx_rdy`=1 and `rd`=0):
  - `rx_data` and both error flags are unchanged.
  - Set `overrun`.
- `rd` with no simultaneous accept clears `rx_rdy` and `overrun`. Error flags hold until the next accept.
- `rd` while `rx_rdy`=0 has no effect.

## Timing
- `rx_rdy` and the new `rx_data` appear on the clk edge after the stop-bit mid-sample. That is about 9.5 bit times after the start falling edge for 8N1, plus up to one tick of detection jitter (the tick is free-running and is not re-phased).
- `rd` takes effect on the next clk edge. A simultaneous accept and `rd` leaves `rx_rdy`=1 holding the new byte.
- Reset asserted mid-frame aborts immediately, with no partial byte and no flags. After release the FSM starts in IDLE and resynchronizes on the next high-to-low transition.
- A line held low continuously gives a frame with `frame_err`=1. On returning to IDLE with `rx_s`=0, reception restarts immediately. This behaviour is accepted.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined**: the PARITY state exists, frames are DATA_BITS+3 bits long, and `parity_err` = XOR(data bits, parity bit) ^ `PARITY_ODD`.
  - **Undefined**: there is no PARITY state, `parity_err` is tied to 0, and `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - `OS_MID`=7 and `OS_LAST`=15;
  - the default `BAUD_DIV`.
- Sub-module `uart_baud_tick` (clk, rst, `tick` out; parameter `BAUD_DIV`) holds the divider. The same sub-module is reused by the transmitter.

## Test plan
- 8N1 frame of 0x55 at BAUD_DIV=4 → `rx_data`=0x55, `rx_rdy`=1, all flags 0; `rd` clears `rx_rdy` the next cycle.
- Low glitch on `rx_s` lasting 4 ticks in IDLE → START aborts at `os_cnt`=7, `rx_rdy` stays 0, and the FSM returns to IDLE.
- Frame 0xA3 with stop bit 0 → `rx_data`=0xA3, `rx_rdy`=1, `frame_err`=1; the next clean frame 0x01 after `rd` gives `frame_err`=0.
- Frames 0x11 then 0x22 with no `rd` → `rx_data`=0x11, `overrun`=1. Repeat with `rd` pulsed exactly on the 0x22 stop sample → `rx_data`=0x22, `rx_rdy`=1, `overrun`=0.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0: 0x07 with parity bit 1 → `parity_err`=0; 0x07 with parity bit 0 → `parity_err`=1.
- `rst` pulsed during DATA bit 4 of frame 0xFF → all outputs 0. The following frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg - definitions shared by the UART receive and transmit paths.
//   rx_state_t   : receiver FSM state encoding
//   OS_MID       : oversample count at the middle of the start bit
//   OS_LAST      : oversample count at the middle of each later bit
//   BAUD_DIV_DEF : default clk cycles per 16x oversample tick (50 MHz, 9600 baud)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic [3:0] OS_MID  = 4'd7;
  localparam logic [3:0] OS_LAST = 4'd15;

  localparam int BAUD_DIV_DEF = 326;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick - free-running 16x oversample tick generator.
// The transmitter uses this divider as well.
//   clk  : in,  system clock, rising edge
//   rst  : in,  asynchronous active-high reset
//   tick : out, one-clk pulse every BAUD_DIV clks (when the count is BAUD_DIV-1)
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx.sv
// uart_rx - UART receive stage. It samples the synchronized serial line at 16x
// the baud rate, deframes start/data/(parity)/stop LSB first, and holds each
// byte for the host with a ready/read handshake and error flags.
//   clk        : in,  system clock, rising edge
//   rst        : in,  asynchronous active-high reset
//   rx_s       : in,  synchronized serial line, idle high
//   rd         : in,  one-cycle strobe; host has consumed rx_data
//   rx_data    : out, last accepted byte (DATA_BITS wide)
//   rx_rdy     : out, holding register contains an unread byte
//   frame_err  : out, stop bit of the accepted byte sampled 0
//   parity_err : out, parity mismatch on the accepted byte
//   overrun    : out, a frame completed while rx_rdy was high and was dropped
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data
// bits. The parity is even when PARITY_ODD is 0 and odd when it is 1. When the
// macro is not defined, parity_err is tied to 0.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | line idle; a low sample on a tick begins a frame
// ST_START  | confirm the start bit at mid-bit (os_cnt = OS_MID)
// ST_DATA   | sample DATA_BITS data bits, one every 16 ticks
// ST_PARITY | sample the parity bit (only with UART_RX_PARITY_EN)
// ST_STOP   | sample the stop bit; accept or discard the byte, then go idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_s,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be in 5..8");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic                 tick;
  rx_state_t            state;
  logic [3:0]           os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_mismatch;
  assign par_mismatch = (^shreg) ^ par_bit ^ (PARITY_ODD != 0);
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // A host read releases the holding register. If a stop-bit accept
      // happens in the same cycle, the STOP branch below overrides this.
      if (rd && rx_rdy) begin
        rx_rdy  <= 1'b0;
        overrun <= 1'b0;
      end

      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state  <= ST_START;
              os_cnt <= '0;
            end
          end

          ST_START: begin
            if (os_cnt == OS_MID) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end

          ST_DATA: begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end

`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              par_bit <= rx_s;
              state   <= ST_STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
`endif

          ST_STOP: begin
            if (os_cnt == OS_LAST) begin
              // Go idle at mid stop bit so that back-to-back frames are caught.
              os_cnt <= '0;
              state  <= ST_IDLE;
              if (!rx_rdy || rd) begin
                rx_data   <= shreg;
                frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                parity_err <= par_mismatch;
`endif
                rx_rdy    <= 1'b1;
                overrun   <= 1'b0;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end

          default: begin
            state  <= ST_IDLE;
            os_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx (BAUD_DIV=4, 8 data bits).
// Each frame pushes its expected holding-register outcome to a queue, and
// that entry is popped and compared once the frame has been received.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BD      = 4;
  localparam int BIT_CLK = 16 * BD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit PODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_s = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_s       (rx_s),
    .rd         (rd),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       rdy;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe,
                          input logic rdy, input logic ovr);
    exp_t e;
    e.data = d; e.fe = fe; e.pe = pe; e.rdy = rdy; e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    int   n;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    n = 0;
    while (e.rdy && !rx_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_data"}, 32'(rx_data), 32'(e.data));
    check({tag, "_ferr"}, 32'(frame_err), 32'(e.fe));
    check({tag, "_perr"}, 32'(parity_err), 32'(e.pe));
    check({tag, "_rdy"}, 32'(rx_rdy), 32'(e.rdy));
    check({tag, "_ovr"}, 32'(overrun), 32'(e.ovr));
  endtask

  // Drives one frame from a negedge, then two bit-times of idle line.
  // When parity is built in, par_flip=1 sends the wrong parity bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    logic [10:0] fr;
    logic        p;
    int          nb;
    p  = (^d) ^ PODD ^ par_flip;
    fr = PAR_EN ? {stop_bit, p, d, 1'b0} : {1'b1, stop_bit, d, 1'b0};
    nb = PAR_EN ? 11 : 10;
    for (int i = 0; i < nb; i++) begin
      rx_s = fr[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_s = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Raise rd for exactly the cycle in which the stop bit is sampled.
  task automatic rd_on_stop();
    int n;
    n = 0;
    while (!(dut.state == ST_STOP && dut.tick && dut.os_cnt == OS_LAST) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("stop_wait_timeout", 32'd0, 32'd1);
    else pulse_rd();
  endtask

  task automatic rst_in_bit4();
    int n;
    n = 0;
    while (!(dut.state == ST_DATA && dut.bit_cnt == 4'd4) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      check("bit4_wait_timeout", 32'd0, 32'd1);
    end else begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rdy"}, 32'(rx_rdy), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_perr"}, 32'(parity_err), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
    check({tag, "_idle"}, 32'(dut.state), 32'(ST_IDLE));
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Clean 8N1 frame, then a host read clears rx_rdy.
    push_exp(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    check_out("f55");
    pulse_rd();
    check("f55_rd_clr", 32'(rx_rdy), 32'd0);

    // Low glitch of 4 ticks: the start bit is rejected.
    rx_s = 1'b0;
    repeat (4 * BD) @(negedge clk);
    rx_s = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("glitch_rdy", 32'(rx_rdy), 32'd0);
    check("glitch_idle", 32'(dut.state), 32'(ST_IDLE));

    // Stop bit 0 gives a framing error, and the next clean frame clears it.
    push_exp(8'hA3, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b0, 1'b0);
    check_out("fA3");
    pulse_rd();
    push_exp(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    check_out("f01");
    pulse_rd();

    // Overrun: the second frame is dropped while 0x11 is still unread.
    push_exp(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    check_out("f11");
    push_exp(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0);
    check_out("f22_ovr");

    // rd on the stop-sample cycle: the new byte is accepted and overrun clears.
    push_exp(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      rd_on_stop();
    join
    check_out("f22_rd");
    pulse_rd();

`ifdef UART_RX_PARITY_EN
    push_exp(8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    check_out("f07_par_ok");
    pulse_rd();
    push_exp(8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    check_out("f07_par_bad");
    pulse_rd();
`endif

    // Leave a byte pending, then reset during data bit 4 of a 0xFF frame.
    push_exp(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    check_out("fC3");
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      rst_in_bit4();
    join
    check_all_zero("midrst");
    push_exp(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_out("f3C");

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
